// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 32-bit ALU: accepts one request, drives the
// ALU operand/opcode registers, waits the opcode-dependent execution time,
// then captures the 64-bit result and holds it until the consumer takes it.
module alu_op_sequencer #(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned BASIC_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_opcode,
    input  logic [WORD_SIZE-1:0]     req_a,
    input  logic [WORD_SIZE-1:0]     req_b,
    output logic [WORD_SIZE-1:0]     alu_A,
    output logic [WORD_SIZE-1:0]     alu_Y,
    output logic [WORD_SIZE-1:0]     alu_B,
    output logic [4:0]               alu_opcode,
    input  logic [2*WORD_SIZE-1:0]   alu_C,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_SIZE-1:0]     z_hi,
    output logic [WORD_SIZE-1:0]     z_lo,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned RES_W = 2 * WORD_SIZE;

    localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BASIC_CNT  = CNT_W'(BASIC_CYCLES - 1);

    localparam logic [OPC_W-1:0] OP_MUL = 5'b00011;
    localparam logic [OPC_W-1:0] OP_DIV = 5'b00100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] y_q, y_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [WORD_SIZE-1:0] zhi_q, zhi_d;
    logic [WORD_SIZE-1:0] zlo_q, zlo_d;
    logic                 rv_q, rv_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 rdy_q, rdy_d;

    logic                 op_illegal;
    logic                 op_muldiv;

    assign op_illegal = (req_opcode == '0) || req_opcode[OPC_W-1];
    assign op_muldiv  = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            y_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            y_q     <= y_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state, operand latch, result capture and handshake flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        y_d     = y_q;
        b_d     = b_q;
        opc_d   = opc_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        rv_d    = rv_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                // rdy_q gates acceptance so the first post-reset cycle honours req_ready=0
                if (rdy_q && req_valid) begin
                    a_d   = req_a;
                    y_d   = req_a;
                    b_d   = req_b;
                    opc_d = req_opcode;
                    if (op_illegal) begin
                        zhi_d   = '0;
                        zlo_d   = '0;
                        err_d   = 1'b1;
                        rv_d    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = op_muldiv ? MULDIV_CNT : BASIC_CNT;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    zhi_d   = alu_C[RES_W-1:WORD_SIZE];
                    zlo_d   = alu_C[WORD_SIZE-1:0];
                    err_d   = 1'b0;
                    rv_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    assign req_ready  = rdy_q;
    assign busy       = busy_q;
    assign alu_A      = a_q;
    assign alu_Y      = y_q;
    assign alu_B      = b_q;
    assign alu_opcode = opc_q;
    assign z_hi       = zhi_q;
    assign z_lo       = zlo_q;
    assign rsp_valid  = rv_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and a
// transaction-level reference for latency and result.
module tb_alu_op_sequencer;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_opcode;
    logic [W-1:0]  req_a, req_b;
    logic [W-1:0]  alu_A, alu_Y, alu_B;
    logic [4:0]    alu_opcode;
    logic [2*W-1:0] alu_C;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  z_hi, z_lo;
    logic          rsp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(
        .WORD_SIZE(W), .MULDIV_CYCLES(4), .BASIC_CYCLES(1)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_A(alu_A), .alu_Y(alu_Y), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_C(alu_C),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .z_hi(z_hi), .z_lo(z_lo), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit is_illegal(input logic [4:0] op);
        return (op == 5'd0) || (op >= 5'd16);
    endfunction

    // Behavioural ALU; illegal opcodes produce zero.
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (is_illegal(op)) return 64'd0;
        case (op)
            5'd1:  return ea + eb;
            5'd2:  return {32'd0, a - b};
            5'd3:  return ea * eb;
            5'd4:  return (b == 0) ? 64'd0 : {a % b, a / b};
            5'd10: return {32'd0, a & b};
            5'd11: return {32'd0, a | b};
            5'd12: return {32'd0, a ^ b};
            default: return {~a, a ^ b ^ {27'd0, op}};
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op);
        if (is_illegal(op)) return 0;
        if (op == 5'd3 || op == 5'd4) return 4;
        return 1;
    endfunction

    assign alu_C = alu_fn(alu_opcode, alu_A, alu_B);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction: accept, execute, hold response `hold` cycles, complete.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pend,
                         input logic [4:0] pop, input logic [31:0] pa, input logic [31:0] pb);
        int w;
        int c;
        logic [63:0] res;
        res = alu_fn(op, a, b);
        w = 0;
        while (!req_ready && w < 20) begin tick(); w++; end
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        tick();
        req_valid = 1'b0;
        chk("alu_A_latched", 64'(alu_A), 64'(a));
        chk("alu_Y_latched", 64'(alu_Y), 64'(a));
        chk("alu_B_latched", 64'(alu_B), 64'(b));
        chk("alu_opcode_latched", 64'(alu_opcode), 64'(op));
        c = 0;
        while (!rsp_valid && c < 40) begin
            chk("busy_exec", 64'(busy), 64'd1);
            chk("req_ready_exec", 64'(req_ready), 64'd0);
            chk("alu_A_stable", 64'(alu_A), 64'(a));
            chk("alu_B_stable", 64'(alu_B), 64'(b));
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        rsp_ready = 1'b0;
        chk("latency", 64'(c), 64'(exp_lat(op)));
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("z_hi", 64'(z_hi), 64'(res[63:32]));
        chk("z_lo", 64'(z_lo), 64'(res[31:0]));
        chk("rsp_err", 64'(rsp_err), 64'(is_illegal(op)));
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                req_valid  = 1'b1;
                req_opcode = pop;
                req_a      = pa;
                req_b      = pb;
            end
            tick();
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_z_lo", 64'(z_lo), 64'(res[31:0]));
            chk("hold_z_hi", 64'(z_hi), 64'(res[63:32]));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_alu_A", 64'(alu_A), 64'(a));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
        chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("z_lo_kept", 64'(z_lo), 64'(res[31:0]));
        if (!pend) req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] exp_z[4];
        int cyc, idx, nresp, last_acc;
        bit acc;

        clr = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_z", {z_hi, z_lo}, 64'd0);
        chk("rst_alu", {alu_A, alu_B}, 64'd0);
        tick(); tick();
        clr = 1'b1;
        tick();
        chk("first_cycle_ready", 64'(req_ready), 64'd1);

        // Add
        do_op(5'b00001, 32'd5, 32'd7, 0, 1'b0, 5'd0, 32'd0, 32'd0);
        // Multi-cycle mul
        do_op(5'b00011, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 5'd0, 32'd0, 32'd0);
        // Backpressure with a pending request held during RESP
        do_op(5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 6, 1'b1, 5'b00001, 32'd100, 32'd23);
        do_op(5'b00001, 32'd100, 32'd23, 0, 1'b0, 5'd0, 32'd0, 32'd0);
        // Illegal opcode then a legal one
        do_op(5'b10101, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0, 5'd0, 32'd0, 32'd0);
        do_op(5'b00010, 32'd50, 32'd8, 0, 1'b0, 5'd0, 32'd0, 32'd0);
        do_op(5'b00000, 32'd1, 32'd2, 0, 1'b0, 5'd0, 32'd0, 32'd0);

        // Reset mid-operation during div
        req_valid = 1'b1; req_opcode = 5'b00100; req_a = 32'd1000; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        #2 clr = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_err", 64'(rsp_err), 64'd0);
        chk("midrst_z", {z_hi, z_lo}, 64'd0);
        chk("midrst_alu_AY", {alu_A, alu_Y}, 64'd0);
        chk("midrst_alu_B_op", {27'd0, alu_opcode, alu_B}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        tick();
        chk("midrst_first_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end

        // Back-to-back adds with req_valid held and rsp_ready high
        for (int i = 0; i < 4; i++) exp_z[i] = 32'(i * 1000 + 17 + i);
        rsp_ready = 1'b1; req_valid = 1'b1; req_opcode = 5'b00001;
        req_a = 32'd17; req_b = 32'd0;
        cyc = 0; idx = 0; nresp = 0; last_acc = -1;
        while (nresp < 4 && cyc < 60) begin
            acc = req_ready && (idx < 4);
            if (rsp_valid) begin
                chk("b2b_z_lo", 64'(z_lo), 64'(exp_z[nresp]));
                nresp++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (idx > 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd3);
                last_acc = cyc;
                idx++;
                if (idx < 4) begin
                    req_a = 32'(idx * 1000 + 17);
                    req_b = 32'(idx);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 64'(nresp), 64'd4);
        rsp_ready = 1'b0; req_valid = 1'b0;
        tick();

        // Randomised transactions against the reference
        for (int i = 0; i < 25; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = $urandom;
            rb  = $urandom;
            do_op(rop, ra, rb, $urandom_range(0, 3), 1'b0, 5'd0, 32'd0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
